flp_add_arbiter: RTL and testbench

FLP_ADD_ARBITER -- requirements
Module: flp_add_arbiter

---
 rtl/FLP_pkg.sv | 29 ++
 rtl/flp_add_arbiter_rr.sv | 46 ++++
 rtl/flp_add_arbiter.sv | 142 ++++++++++++++
 tb/tb_flp_add_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/FLP_pkg.sv
// FLP_pkg: floating point format and shared-adder constants.
// Single-precision layout plus ownership tag type for the adder arbiter.
package FLP_pkg;

    localparam int EXPONENT_BITS    = 8;
    localparam int SIGNIFICANT_BITS = 23;
    localparam int OVERALL_BITS     = 1 + EXPONENT_BITS + SIGNIFICANT_BITS;

    localparam int FLP_ADD_LATENCY  = 5;
    localparam int FLP_NUM_REQ      = 4;

    // Wide enough for the largest supported requester count (8).
    localparam int TAG_ID_BITS      = 3;

    typedef struct packed {
        logic                   valid;
        logic [TAG_ID_BITS-1:0] id;
    } tag_t;

    function automatic logic [OVERALL_BITS-1:0] flp_negate(
        input logic [OVERALL_BITS-1:0] x
    );
        logic [OVERALL_BITS-1:0] r;
        r = x;
        r[EXPONENT_BITS+SIGNIFICANT_BITS] = ~x[EXPONENT_BITS+SIGNIFICANT_BITS];
        return r;
    endfunction

endpackage

// File: rtl/flp_add_arbiter_rr.sv
// rr_arbiter: round-robin one-hot grant among N requesters.
// Search starts one past the last granted index; state moves only on a grant.
import FLP_pkg::*;

module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          enable,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] last_grant;
    logic          found;
    logic [IW-1:0] sel;

    // Pick the first valid requester after last_grant, wrapping around.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sel       = '0;
        for (int k = 1; k <= N; k++) begin
            sel = IW'((int'(last_grant) + k) % N);
            if (enable && !found && req[sel]) begin
                found      = 1'b1;
                grant[sel] = 1'b1;
                grant_idx  = sel;
            end
        end
    end

    // Remember the winner; reset points at N-1 so requester 0 goes first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= IW'(N - 1);
        end else if (found) begin
            last_grant <= grant_idx;
        end
    end

endmodule

// File: rtl/flp_add_arbiter.sv
// flp_add_arbiter: shares one pipelined FLP adder among NUM_REQ requesters.
// A tag pipe mirrors the adder latency to route each result to its owner.
import FLP_pkg::*;

module flp_add_arbiter #(
    parameter int NUM_REQ     = FLP_NUM_REQ,
    parameter int ADD_LATENCY = FLP_ADD_LATENCY
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            pause,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0]              req_sub,
    input  logic [NUM_REQ*OVERALL_BITS-1:0] req_a,
    input  logic [NUM_REQ*OVERALL_BITS-1:0] req_b,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            add_start,
    output logic [OVERALL_BITS-1:0]         add_a,
    output logic [OVERALL_BITS-1:0]         add_b,
    input  logic                            add_valid,
    input  logic [OVERALL_BITS-1:0]         add_result,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [OVERALL_BITS-1:0]         rsp_data,
    output logic                            busy,
    output logic                            tag_error
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int MW = $clog2(ADD_LATENCY + 1);

    logic [NUM_REQ-1:0]      grant;
    logic [IW-1:0]           grant_idx;
    logic                    any_grant;
    logic                    issue_valid;
    logic [IW-1:0]           issue_id;
    tag_t                    tag_q [ADD_LATENCY];
    tag_t                    tag_out;
    logic                    tag_any;
    logic [MW-1:0]           mask_q;
    logic                    masked;
    logic [OVERALL_BITS-1:0] sel_a;
    logic [OVERALL_BITS-1:0] sel_b;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .enable    (!pause && !rst),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;
    assign any_grant = |grant;
    assign add_start = issue_valid;
    assign tag_out   = tag_q[ADD_LATENCY-1];
    assign masked    = (mask_q != '0);

    // Operand mux for the granted requester; subtraction flips b's sign.
    always_comb begin
        sel_a = req_a[int'(grant_idx)*OVERALL_BITS +: OVERALL_BITS];
        sel_b = req_b[int'(grant_idx)*OVERALL_BITS +: OVERALL_BITS];
        if (req_sub[grant_idx]) begin
            sel_b = flp_negate(sel_b);
        end
    end

    // Issue register: operands only load on a grant so they hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_valid <= 1'b0;
            issue_id    <= '0;
            add_a       <= '0;
            add_b       <= '0;
        end else begin
            issue_valid <= any_grant;
            if (any_grant) begin
                issue_id <= grant_idx;
                add_a    <= sel_a;
                add_b    <= sel_b;
            end
        end
    end

    // Ownership tags travel alongside the adder pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < ADD_LATENCY; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            tag_q[0] <= '{valid: issue_valid, id: TAG_ID_BITS'(issue_id)};
            for (int k = 1; k < ADD_LATENCY; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    // Post-reset window in which leftover adder results are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q <= MW'(ADD_LATENCY);
        end else if (masked) begin
            mask_q <= mask_q - 1'b1;
        end
    end

    // Route the result to the tagged owner one cycle after add_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= tag_out.valid ? (NUM_REQ'(1) << tag_out.id) : '0;
            if (tag_out.valid) begin
                rsp_data <= add_result;
            end
        end
    end

    // Sticky flag when the adder and the tag pipe disagree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_error <= 1'b0;
        end else if (!masked && (add_valid != tag_out.valid)) begin
            tag_error <= 1'b1;
        end
    end

    // Any valid held anywhere in the issue, tag or response stages.
    always_comb begin
        tag_any = 1'b0;
        for (int k = 0; k < ADD_LATENCY; k++) begin
            tag_any = tag_any | tag_q[k].valid;
        end
        busy = issue_valid | tag_any | (|rsp_valid);
    end

endmodule

// File: tb/tb_flp_add_arbiter.sv
// tb_flp_add_arbiter: directed vectors with a result scoreboard.
// Stub adder has fixed latency and no reset, like the real one.
import FLP_pkg::*;

module tb_flp_add_arbiter;

    localparam int N = FLP_NUM_REQ;
    localparam int L = FLP_ADD_LATENCY;
    localparam int W = OVERALL_BITS;

    logic             clk = 1'b0;
    logic             rst;
    logic             pause;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_sub;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     req_ready;
    logic             add_start;
    logic [W-1:0]     add_a;
    logic [W-1:0]     add_b;
    logic             add_valid;
    logic [W-1:0]     add_result;
    logic [N-1:0]     rsp_valid;
    logic [W-1:0]     rsp_data;
    logic             busy;
    logic             tag_error;

    logic [W-1:0]     va   [N];
    logic [W-1:0]     vb   [N];
    logic [W-1:0]     vexp [N];
    logic             vs   [N];
    logic             inject;

    logic             pv [L];
    logic [W-1:0]     pr [L];

    int               q_id [$];
    logic [W-1:0]     q_dat [$];
    int               n_cmp = 0;
    int               n_err = 0;

    flp_add_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .pause      (pause),
        .req_valid  (req_valid),
        .req_sub    (req_sub),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .add_start  (add_start),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_valid  (add_valid),
        .add_result (add_result),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .busy       (busy),
        .tag_error  (tag_error)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_a   = '0;
        req_b   = '0;
        req_sub = '0;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = va[i];
            req_b[i*W +: W] = vb[i];
            req_sub[i]      = vs[i];
        end
    end

    function automatic real sp2r(input logic [31:0] x);
        logic [63:0] d;
        logic [10:0] e;
        e = {3'b000, x[30:23]} + 11'd896;
        if (x[30:0] == 31'd0) d = {x[31], 63'd0};
        else                  d = {x[31], e, x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        return {d[63], e[7:0], d[51:29]};
    endfunction

    initial begin
        for (int k = 0; k < L; k++) begin
            pv[k] = 1'b0;
            pr[k] = '0;
        end
    end

    // Stub adder pipeline, deliberately not reset.
    always @(posedge clk) begin
        pv[0] <= add_start;
        pr[0] <= r2sp(sp2r(add_a) + sp2r(add_b));
        for (int k = 1; k < L; k++) begin
            pv[k] <= pv[k-1];
            pr[k] <= pr[k-1];
        end
    end

    assign add_valid  = pv[L-1] | inject;
    assign add_result = pr[L-1];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard push on every accepted request.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    q_id.push_back(i);
                    q_dat.push_back(vexp[i]);
                end
            end
        end
    end

    // Monitor: pop and compare whenever a response strobe appears.
    always @(negedge clk) begin
        if (!rst && rsp_valid != '0) begin
            if (q_id.size() == 0) begin
                chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                int id;
                logic [W-1:0] dat;
                id  = q_id.pop_front();
                dat = q_dat.pop_front();
                chk("rsp_owner", 32'(rsp_valid), 32'(1) << id);
                chk("rsp_data", rsp_data, dat);
            end
        end
    end

    task automatic set_op(input int i, input logic [31:0] a,
                          input logic [31:0] b, input logic s,
                          input logic [31:0] e);
        va[i]   = a;
        vb[i]   = b;
        vs[i]   = s;
        vexp[i] = e;
    endtask

    task automatic load_default_ops();
        set_op(0, 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000);
        set_op(1, 32'h3F800000, 32'h3F000000, 1'b0, 32'h3FC00000);
        set_op(2, 32'h40000000, 32'h40000000, 1'b0, 32'h40800000);
        set_op(3, 32'h40000000, 32'h3F000000, 1'b0, 32'h40200000);
    endtask

    task automatic wait_idle(input int max);
        int k;
        k = 0;
        @(negedge clk);
        while (k < max && (busy || q_id.size() != 0)) begin
            @(negedge clk);
            k++;
        end
        chk("drain_busy", 32'(busy), 32'd0);
        chk("drain_queue", q_id.size(), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        pause     = 1'b0;
        inject    = 1'b0;
        req_valid = '1;
        load_default_ops();

        // Reset state, requests held high to show grants are blocked.
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_start", 32'(add_start), 32'd0);
        chk("rst_rsp", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tagerr", 32'(tag_error), 32'd0);

        // All four valid: 0,1,2,3,0,... one grant per cycle.
        @(posedge clk); #1 rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("rr_grant", 32'(req_ready), 32'(1) << (k % 4));
        end
        @(posedge clk); #1 req_valid = '0;
        wait_idle(40);
        chk("rr_tagerr", 32'(tag_error), 32'd0);

        // Requester 2 subtract: 3.0 - 1.25 = 1.75.
        @(posedge clk); #1;
        set_op(2, 32'h40400000, 32'h3FA00000, 1'b1, 32'h3FE00000);
        req_valid = 4'b0100;
        @(negedge clk);
        chk("sub_ready", 32'(req_ready), 32'h4);
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        chk("sub_start", 32'(add_start), 32'd1);
        chk("sub_add_a", add_a, 32'h40400000);
        chk("sub_add_b", add_b, 32'hBFA00000);
        wait_idle(40);
        chk("hold_add_b", add_b, 32'hBFA00000);
        chk("hold_start", 32'(add_start), 32'd0);
        load_default_ops();

        // Pause mid-stream: no grants, in-flight results still land.
        @(posedge clk); #1 req_valid = '1;
        repeat (2) @(posedge clk);
        #1 pause = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("pause_ready", 32'(req_ready), 32'd0);
        end
        wait_idle(40);
        @(posedge clk); #1 req_valid = '0; pause = 1'b0;

        // Reset with three ops in flight; stale adder valids are dropped.
        @(posedge clk); #1 req_valid = '1;
        repeat (3) @(posedge clk);
        #1 req_valid = '0;
        @(posedge clk); #1 rst = 1'b1;
        q_id.delete();
        q_dat.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < L + 4; k++) begin
            @(negedge clk);
            chk("flush_rsp", 32'(rsp_valid), 32'd0);
            chk("flush_tagerr", 32'(tag_error), 32'd0);
        end
        chk("flush_busy", 32'(busy), 32'd0);

        // Spurious adder valid after masking: sticky tag_error.
        @(posedge clk); #1 inject = 1'b1;
        @(posedge clk); #1 inject = 1'b0;
        @(negedge clk);
        chk("tagerr_set", 32'(tag_error), 32'd1);
        repeat (5) @(negedge clk);
        chk("tagerr_sticky", 32'(tag_error), 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("tagerr_clr", 32'(tag_error), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
